length_fetch_scheduler: RTL
===========================

LENGTH_FETCH_SCHEDULER -- requirements
Module: length_fetch_scheduler

Interface
REQ-001 Parameter CHANNEL_NUM, 8, number of channel FIFOs sharing the ROM.
REQ-002 Parameter CHANNEL_LOG, 3, width of channel index.
REQ-003 Parameter ADDR_W, 9, ROM address width.
REQ-004 Parameter DATA_W, 8, ROM word / FIFO data width.
REQ-005 Parameter FIFO_DEPTH, 16, entries per channel FIFO; credit ceiling.
REQ-006 Parameter MATRIX_NUM, 3, matrices fetched per run.
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 start  in  1  one-cycle run request.
REQ-010 base_addr  in  CHANNEL_NUM*ADDR_W  channel i start address in slice [i*ADDR_W+:ADDR_W]; sampled on accepted start.
REQ-011 seg_len  in  CHANNEL_NUM*ADDR_W  words per channel per matrix; same slicing; sampled on accepted start.
REQ-012 fifo_pop  in  CHANNEL_NUM  consumer read strobe per channel FIFO (credit return).
REQ-013 rom_addr  out  ADDR_W  shared ROM address.
REQ-014 rom_data  in  DATA_W  ROM output, valid one cycle after address.
REQ-015 fifo_din  out  DATA_W  write data to all FIFOs.
REQ-016 fifo_wr_en  out  CHANNEL_NUM  one-hot-or-zero FIFO write strobe.
REQ-017 matrix  out  2  index of matrix being fetched.
REQ-018 busy  out  1  high from accepted start until done.
REQ-019 done  out  1  one-cycle pulse when the run completes.

Function
REQ-020 States: IDLE, FETCH, DRAIN, DONE.
REQ-021 IDLE: start=1 -> load addr[i]=base_addr[i], remaining[i]=seg_len[i], matrix=0, go FETCH; start ignored in other states.
REQ-022 Channel eligible iff remaining[i]>0 and credit[i]>0.
REQ-023 FETCH: round-robin grant of at most one eligible channel per cycle, search starting at (last_grant+1) mod CHANNEL_NUM; last_grant resets to CHANNEL_NUM-1.
REQ-024 Issue cycle t: rom_addr=addr[g] combinationally; edge ending t: addr[g]+=1, remaining[g]-=1, credit[g]-=1, tag {valid,g} registered.
REQ-025 Cycle t+1: fifo_wr_en[g]=1, fifo_din=rom_data; fifo_wr_en=0 when tag invalid.
REQ-026 No issue cycle: rom_addr holds last value; no state change.
REQ-027 credit[i] resets/loads to FIFO_DEPTH; fifo_pop[i] increments; pop and issue same cycle -> unchanged; credit never exceeds FIFO_DEPTH nor goes below 0 (pop at FIFO_DEPTH ignored).
REQ-028 Credits persist across matrices; not reloaded on matrix advance.
REQ-029 FETCH -> DRAIN when all remaining[i]=0.
REQ-030 DRAIN: wait until tag invalid; then if matrix<MATRIX_NUM-1: matrix+=1, remaining[i]=stored seg_len[i], addr continues contiguously, go FETCH; else go DONE.
REQ-031 Channel with seg_len 0 is never granted; all zero -> FETCH exits next cycle, run completes with no writes.
REQ-032 DONE: done=1 for one cycle, busy=0 next cycle, return IDLE.
REQ-033 addr wraps modulo 2^ADDR_W; no error flag.

Reset
REQ-034 rst=1 (any cycle, including mid-run): state=IDLE, busy=0, done=0, matrix=0, fifo_wr_en=0, fifo_din=0, rom_addr=0, tag invalid, all credit=FIFO_DEPTH, remaining=0, addr=0; in-flight ROM read discarded.

Verification
REQ-035 CHANNEL_NUM=8, base_addr[i]=i*16, seg_len all 2, no backpressure -> grants 0..7,0..7 per matrix, 48 writes total, addresses per channel contiguous across matrices (ch0: 0..5), done after last write.
REQ-036 seg_len[3]=20, others 0, fifo_pop never -> exactly 16 writes to ch3 then stall; one pop -> one more write the cycle after next.
REQ-037 Pop and issue same cycle on ch0 with credit=1 -> credit stays 1; ch0 remains eligible.
REQ-038 All seg_len=0 -> busy high, done pulse, zero fifo_wr_en, matrix steps 0->2.
REQ-039 rst asserted cycle after an issue -> no fifo_wr_en next cycle, all outputs at reset values; new start runs cleanly from base_addr.
REQ-040 start pulse while busy -> ignored; base_addr change mid-run has no effect.

Source files
------------

// File: rtl/length_fetch_scheduler.sv
// Shared-ROM fetch scheduler: streams MATRIX_NUM matrices of per-channel
// segments from one ROM into CHANNEL_NUM credit-controlled FIFOs.
// Ports:
//   clk, rst        clock, async active-high reset
//   start           one-cycle run request (ignored unless idle)
//   base_addr       per-channel start address, slice i = [i*ADDR_W +: ADDR_W]
//   seg_len         per-channel words per matrix, same slicing
//   fifo_pop        per-channel consumer read strobe (credit return)
//   rom_addr        shared ROM address (combinational on an issue cycle)
//   rom_data        ROM word, valid one cycle after rom_addr
//   fifo_din        write data to all FIFOs
//   fifo_wr_en      one-hot-or-zero FIFO write strobe
//   matrix          index of the matrix being fetched
//   busy, done      run in progress / one-cycle completion pulse
module length_fetch_scheduler #(
    parameter int unsigned CHANNEL_NUM = 8,
    parameter int unsigned CHANNEL_LOG = 3,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned MATRIX_NUM  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CHANNEL_NUM*ADDR_W-1:0] base_addr,
    input  logic [CHANNEL_NUM*ADDR_W-1:0] seg_len,
    input  logic [CHANNEL_NUM-1:0]        fifo_pop,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [DATA_W-1:0]             rom_data,
    output logic [DATA_W-1:0]             fifo_din,
    output logic [CHANNEL_NUM-1:0]        fifo_wr_en,
    output logic [1:0]                    matrix,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned             CREDIT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CREDIT_W-1:0]     CREDIT_MAX  = CREDIT_W'(FIFO_DEPTH);
    localparam logic [CHANNEL_LOG-1:0]  LAST_CH     = CHANNEL_LOG'(CHANNEL_NUM - 1);
    localparam logic [1:0]              LAST_MATRIX = 2'(MATRIX_NUM - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                   state, state_nxt;
    logic [ADDR_W-1:0]        addr_q      [CHANNEL_NUM];
    logic [ADDR_W-1:0]        remaining_q [CHANNEL_NUM];
    logic [ADDR_W-1:0]        seg_q       [CHANNEL_NUM];
    logic [CREDIT_W-1:0]      credit_q    [CHANNEL_NUM];
    logic [CHANNEL_LOG-1:0]   last_grant, grant, tag_ch;
    logic                     tag_valid, issue, all_done, load, advance;
    logic [CHANNEL_NUM-1:0]   eligible;
    logic [ADDR_W-1:0]        rom_addr_q;

    assign load    = (state == IDLE) && start;
    assign advance = (state == DRAIN) && !tag_valid && (matrix < LAST_MATRIX);

    // Eligibility and end-of-matrix detection
    always_comb begin
        all_done = 1'b1;
        eligible = '0;
        for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
            eligible[i] = (remaining_q[i] != '0) && (credit_q[i] != '0);
            if (remaining_q[i] != '0) all_done = 1'b0;
        end
    end

    // Round-robin search starting just after the last granted channel
    always_comb begin
        logic [CHANNEL_LOG-1:0] idx;
        issue = 1'b0;
        grant = '0;
        idx   = '0;
        for (int unsigned k = 0; k < CHANNEL_NUM; k++) begin
            idx = CHANNEL_LOG'((32'(last_grant) + 32'd1 + k) % CHANNEL_NUM);
            if (!issue && eligible[idx]) begin
                issue = 1'b1;
                grant = idx;
            end
        end
        if (state != FETCH) issue = 1'b0;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (all_done) state_nxt = DRAIN;
            DRAIN:   if (!tag_valid) state_nxt = (matrix < LAST_MATRIX) ? FETCH : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: status decode, write strobe from the registered tag, ROM address
    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        fifo_wr_en = '0;
        fifo_din   = '0;
        if (tag_valid) begin
            fifo_wr_en[tag_ch] = 1'b1;
            fifo_din           = rom_data;
        end
        rom_addr = issue ? addr_q[grant] : rom_addr_q;
    end

    // Per-channel address, remaining count and credit bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
                addr_q[i]      <= '0;
                remaining_q[i] <= '0;
                seg_q[i]       <= '0;
                credit_q[i]    <= CREDIT_MAX;
            end
            matrix     <= '0;
            last_grant <= LAST_CH;
            tag_valid  <= 1'b0;
            tag_ch     <= '0;
            rom_addr_q <= '0;
        end else begin
            tag_valid <= issue;
            if (issue) begin
                tag_ch     <= grant;
                last_grant <= grant;
                rom_addr_q <= addr_q[grant];
            end
            for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
                if (load) begin
                    addr_q[i]      <= base_addr[i*ADDR_W +: ADDR_W];
                    remaining_q[i] <= seg_len[i*ADDR_W +: ADDR_W];
                    seg_q[i]       <= seg_len[i*ADDR_W +: ADDR_W];
                    credit_q[i]    <= CREDIT_MAX;
                end else begin
                    if (issue && (grant == CHANNEL_LOG'(i))) begin
                        addr_q[i]      <= addr_q[i] + 1'b1;
                        remaining_q[i] <= remaining_q[i] - 1'b1;
                        // A same-cycle pop cancels the issue's credit use
                        if (!fifo_pop[i]) credit_q[i] <= credit_q[i] - 1'b1;
                    end else begin
                        if (advance) remaining_q[i] <= seg_q[i];
                        if (fifo_pop[i] && (credit_q[i] != CREDIT_MAX))
                            credit_q[i] <= credit_q[i] + 1'b1;
                    end
                end
            end
            if (load)         matrix <= '0;
            else if (advance) matrix <= matrix + 2'd1;
        end
    end

endmodule
